decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_3to8.sv | 18 +
 rtl/decoder.sv | 48 ++++
 tb/tb_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the register write-select decoder.
// Imported by the decoder RTL and its bench.
package decoder_pkg;

    localparam int ADDR_W = 5;
    localparam int SEL_W = 32;
    localparam logic [SEL_W-1:0] SEL_RST = 32'h0;

    // True when more than one bit of v is set (zero and one-hot are legal).
    function automatic logic onehot_bad(input logic [SEL_W-1:0] v);
        return (v & (v - SEL_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder leaf, pure gate-level AND terms.
// All outputs are zero when en is low.
module decoder_3to8 (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] y
);

    assign y[0] = en & ~a[2] & ~a[1] & ~a[0];
    assign y[1] = en & ~a[2] & ~a[1] &  a[0];
    assign y[2] = en & ~a[2] &  a[1] & ~a[0];
    assign y[3] = en & ~a[2] &  a[1] &  a[0];
    assign y[4] = en &  a[2] & ~a[1] & ~a[0];
    assign y[5] = en &  a[2] & ~a[1] &  a[0];
    assign y[6] = en &  a[2] &  a[1] & ~a[0];
    assign y[7] = en &  a[2] &  a[1] &  a[0];

endmodule

// File: rtl/decoder.sv
// 5-to-32 register write-select decoder built from four 3-to-8 leaves,
// with a registered copy of the select and a one-hot self-check flag.
module decoder
    import decoder_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd,
    input  logic              WE,
    output logic [SEL_W-1:0]  out,
    output logic [SEL_W-1:0]  out_q,
    output logic              onehot_err
);

    logic [3:0] grp_en;
    logic       err_d;

    // Upper index bits pick one bank of eight, gated by the write enable.
    assign grp_en[0] = WE & ~rd[4] & ~rd[3];
    assign grp_en[1] = WE & ~rd[4] &  rd[3];
    assign grp_en[2] = WE &  rd[4] & ~rd[3];
    assign grp_en[3] = WE &  rd[4] &  rd[3];

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_bank
            decoder_3to8 u_dec (
                .a  (rd[2:0]),
                .en (grp_en[k]),
                .y  (out[8*k+7:8*k])
            );
        end
    endgenerate

    assign err_d = onehot_bad(out);

    // Register the select and its structural check every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q      <= SEL_RST;
            onehot_err <= 1'b0;
        end else begin
            out_q      <= out;
            onehot_err <= err_d;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the 5-to-32 write-select decoder.
// Each task drives one scenario and checks its own expectations.
module tb_decoder;
    import decoder_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] rd;
    logic              WE;
    logic [SEL_W-1:0]  out;
    logic [SEL_W-1:0]  out_q;
    logic              onehot_err;

    int checks = 0;
    int failures = 0;

    decoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd         (rd),
        .WE         (WE),
        .out        (out),
        .out_q      (out_q),
        .onehot_err (onehot_err)
    );

    always #5 clock = ~clock;

    // Starts at time 0: rd steps every 10 ns, WE toggles every 20 ns.
    task automatic test_comb_sweep();
        logic [SEL_W-1:0] exp;
        for (int i = 0; i < 32; i++) begin
            rd = i[4:0];
            WE = i[1];
            exp = WE ? (32'h1 << i) : 32'h0;
            #1;
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL sweep t=%0t rd=%0d we=%0b out=%h exp=%h",
                         $time, rd, WE, out, exp);
            end
            #9;
        end
    endtask

    // Reset held since time 0, then released between edges.
    task automatic test_reset();
        checks++;
        if (out_q !== SEL_RST || onehot_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state out_q=%h err=%b exp=%h/0",
                     out_q, onehot_err, SEL_RST);
        end
        @(negedge clock);
        rd = 5'd31;
        WE = 1'b1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_q !== SEL_RST) begin
            failures++;
            $display("FAIL reset_release_hold out_q=%h exp=%h",
                     out_q, SEL_RST);
        end
        @(posedge clock);
        #1;
        checks++;
        if (out_q !== 32'h80000000) begin
            failures++;
            $display("FAIL reset_first_edge out_q=%h exp=80000000", out_q);
        end
    endtask

    // WE high, rd 0..31 walks a single one, then wraps 31 -> 0.
    task automatic test_walk();
        logic [SEL_W-1:0] exp;
        WE = 1'b1;
        exp = 32'h1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            rd = i[4:0];
            #1;
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL walk rd=%0d out=%h exp=%h", rd, out, exp);
            end
            exp = {exp[30:0], exp[31]};
        end
        @(negedge clock);
        rd = rd + 5'd1;
        #1;
        checks++;
        if (out !== 32'h00000001) begin
            failures++;
            $display("FAIL wrap rd=%0d out=%h exp=00000001", rd, out);
        end
    endtask

    // One-cycle latency of out_q after a fresh reset.
    task automatic test_latency();
        @(negedge clock);
        reset_n = 1'b0;
        rd = 5'd5;
        WE = 1'b1;
        #2;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_q !== 32'h0) begin
            failures++;
            $display("FAIL latency_pre out_q=%h exp=00000000", out_q);
        end
        @(posedge clock);
        #1;
        checks++;
        if (out_q !== 32'h00000020) begin
            failures++;
            $display("FAIL latency_post out_q=%h exp=00000020", out_q);
        end
    endtask

    // Asynchronous reset pulse while out_q holds index 5.
    task automatic test_async_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_q !== 32'h0 || onehot_err !== 1'b0) begin
            failures++;
            $display("FAIL async_clear out_q=%h err=%b exp=0/0",
                     out_q, onehot_err);
        end
        checks++;
        if (out !== 32'h00000020) begin
            failures++;
            $display("FAIL out_in_reset out=%h exp=00000020", out);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out_q !== 32'h00000020) begin
            failures++;
            $display("FAIL reload out_q=%h exp=00000020", out_q);
        end
    endtask

    // A pending index changed under reset must not reappear.
    task automatic test_stale();
        @(negedge clock);
        rd = 5'd9;
        #1;
        reset_n = 1'b0;
        rd = 5'd3;
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out_q !== 32'h00000008) begin
            failures++;
            $display("FAIL stale out_q=%h exp=00000008", out_q);
        end
    endtask

    // All 64 rd/WE pairs: exact decode, registered copy, no error flag.
    task automatic test_exhaustive();
        logic [SEL_W-1:0] exp;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) begin
                @(negedge clock);
                WE = w[0];
                rd = i[4:0];
                exp = (w == 1) ? (32'h1 << i) : 32'h0;
                @(posedge clock);
                #1;
                checks++;
                if (out !== exp || $countones(out) > 1) begin
                    failures++;
                    $display("FAIL exh_out we=%0d rd=%0d out=%h exp=%h",
                             w, i, out, exp);
                end
                checks++;
                if (out_q !== exp || onehot_err !== 1'b0) begin
                    failures++;
                    $display("FAIL exh_q we=%0d rd=%0d out_q=%h err=%b exp=%h/0",
                             w, i, out_q, onehot_err, exp);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rd = '0;
        WE = 1'b0;
        test_comb_sweep();
        test_reset();
        test_walk();
        test_latency();
        test_async_reset();
        test_stale();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
